// File: rtl/mux_arbiter_pkg.sv
// Shared types for the three-way round-robin output arbiter.
// Select encoding doubles as the requester index; the value 3 is never produced.
package mux_arb_pkg;

    localparam int N_REQ = 3;

    typedef enum logic [1:0] {
        SEL_ALPHA = 2'd0,
        SEL_BETA  = 2'd1,
        SEL_GAMMA = 2'd2
    } sel_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // Round-robin successor; anything at or beyond gamma wraps back to alpha.
    function automatic sel_t next_sel(input sel_t s);
        if (s == SEL_ALPHA) return SEL_BETA;
        if (s == SEL_BETA)  return SEL_GAMMA;
        return SEL_ALPHA;
    endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/data/handshake bundle between three requesters, the arbiter and the downstream sink.
// The arbiter takes the slave view; the requester/sink side takes the master view.
interface mux_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        req;
    logic [DATA_W-1:0] alpha;
    logic [DATA_W-1:0] beta;
    logic [DATA_W-1:0] gamma;
    logic [2:0]        ack;
    logic [1:0]        sel;
    logic              cs;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output req, alpha, beta, gamma, out_ready,
        input  ack, sel, cs, out_valid, out_data
    );

    modport slave (
        input  req, alpha, beta, gamma, out_ready,
        output ack, sel, cs, out_valid, out_data
    );
endinterface

// File: rtl/mux_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, last (mod 3).
module rr_pick3
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             last,
    output sel_t             pick,
    output logic             any
);
    sel_t c1;
    sel_t c2;
    sel_t c3;

    assign c1  = next_sel(last);
    assign c2  = next_sel(c1);
    assign c3  = next_sel(c2);
    assign any = |req;

    always_comb begin
        pick = SEL_ALPHA;
        if (req[c1]) begin
            pick = c1;
        end else if (req[c2]) begin
            pick = c2;
        end else if (req[c3]) begin
            pick = c3;
        end
    end
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter steering one of three sources onto a shared valid/ready output channel.
// Define MUX_ARB_STATS_EN to add saturating per-requester grant counters with a synchronous clear.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef MUX_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic             clk,
    input  logic             nReset,
    mux_arbiter_if.slave     bus
`ifdef MUX_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b,
    output logic [CNT_W-1:0] grant_cnt_c
`endif
);
    arb_state_t        state_q;
    arb_state_t        state_d;
    sel_t              sel_q;
    sel_t              sel_d;
    sel_t              last_q;
    sel_t              last_d;
    sel_t              arb_last;
    sel_t              pick;
    logic              cs_q;
    logic              cs_d;
    logic              any;
    logic              accept;
    logic [2:0]        arb_req;
    logic [2:0]        ack_d;
    logic [DATA_W-1:0] mux_data;

    assign accept = cs_q & bus.out_ready;

    // While busy the current owner is masked and the scan restarts just after it.
    always_comb begin
        arb_req  = bus.req;
        arb_last = last_q;
        if (state_q == ARB_BUSY) begin
            arb_req  = bus.req & ~(3'b001 << sel_q);
            arb_last = sel_q;
        end
    end

    rr_pick3 u_pick (
        .req  (arb_req),
        .last (arb_last),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ARB_IDLE;
            sel_q   <= SEL_ALPHA;
            cs_q    <= 1'b0;
            last_q  <= SEL_GAMMA;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cs_q    <= cs_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cs_d    = cs_q;
        last_d  = last_q;
        ack_d   = 3'b000;
        unique case (state_q)
            ARB_IDLE: begin
                cs_d = 1'b0;
                if (any) begin
                    sel_d   = pick;
                    cs_d    = 1'b1;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // An accept outranks a request that was withdrawn in the same cycle.
                if (accept) begin
                    ack_d  = 3'b001 << sel_q;
                    last_d = sel_q;
                    if (any) begin
                        sel_d = pick;
                    end else begin
                        cs_d    = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end else if (!bus.req[sel_q]) begin
                    cs_d    = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                cs_d    = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        mux_data = '0;
        if (cs_q) begin
            case (sel_q)
                SEL_ALPHA: mux_data = bus.alpha;
                SEL_BETA:  mux_data = bus.beta;
                SEL_GAMMA: mux_data = bus.gamma;
                default:   mux_data = '0;
            endcase
        end
    end

    assign bus.ack       = ack_d;
    assign bus.sel       = sel_q;
    assign bus.cs        = cs_q;
    assign bus.out_valid = cs_q;
    assign bus.out_data  = mux_data;

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt [N_REQ];

    // ack_d is already the one-hot of the accepted requester, so it selects the counter.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (stats_clr) begin
                    grant_cnt[i] <= '0;
                end else if (ack_d[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt_a = grant_cnt[0];
    assign grant_cnt_b = grant_cnt[1];
    assign grant_cnt_c = grant_cnt[2];
`endif
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed and randomized bench for mux_arbiter, checked against a cycle-level behavioural model.
// With MUX_ARB_STATS_EN defined the DUT is built with 2-bit counters so saturation is reachable.
module tb_mux_arbiter;
    localparam int DATA_W = 8;
`ifdef MUX_ARB_STATS_EN
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    logic              clk = 1'b0;
    logic              nReset = 1'b1;
    logic [2:0]        req = 3'b000;
    logic [DATA_W-1:0] src [3];
    logic              out_ready = 1'b0;
    int                n_cmp = 0;
    int                n_fail = 0;
    int                m_grant;
    int                m_last;
    logic [2:0]        last_ack;
`ifdef MUX_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_c;
    int                m_cnt [3];
`endif

    mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    assign bus.req       = req;
    assign bus.alpha     = src[0];
    assign bus.beta      = src[1];
    assign bus.gamma     = src[2];
    assign bus.out_ready = out_ready;

    mux_arbiter #(
        .DATA_W (DATA_W)
`ifdef MUX_ARB_STATS_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .bus         (bus)
`ifdef MUX_ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .grant_cnt_a (cnt_a),
        .grant_cnt_b (cnt_b),
        .grant_cnt_c (cnt_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the first requester with req set, scanning upward from base+1 modulo three; -1 if none.
    function automatic int rr_model(input logic [2:0] r, input int base);
        for (int k = 1; k <= 3; k++) begin
            int idx = (base + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_grant  = -1;
        m_last   = 2;
        last_ack = 3'b000;
`ifdef MUX_ARB_STATS_EN
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
`endif
    endtask

    task automatic model_step();
        int owner;
        owner = m_grant;
        if (owner < 0) begin
            m_grant = rr_model(req, m_last);
        end else if (out_ready) begin
            m_last  = owner;
            m_grant = rr_model(req & ~(3'b001 << owner), owner);
        end else if (!req[owner]) begin
            m_grant = -1;
        end
`ifdef MUX_ARB_STATS_EN
        if (stats_clr) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else if (owner >= 0 && out_ready && m_cnt[owner] < CNT_MAX) begin
            m_cnt[owner] = m_cnt[owner] + 1;
        end
`endif
    endtask

    // Compares every output against the model mid-cycle, then advances one clock edge.
    task automatic tick();
        logic       e_cs;
        logic [2:0] e_ack;
        logic [7:0] e_data;
        @(negedge clk);
        e_cs   = (m_grant >= 0);
        e_ack  = 3'b000;
        e_data = 8'h00;
        if (e_cs) begin
            e_data = src[m_grant];
            if (out_ready) e_ack = 3'b001 << m_grant;
        end
        check("cs", bus.cs, e_cs);
        check("out_valid", bus.out_valid, e_cs);
        check("ack", bus.ack, e_ack);
        check("out_data", bus.out_data, e_data);
        if (e_cs) check("sel", bus.sel, m_grant);
`ifdef MUX_ARB_STATS_EN
        check("cnt_a", cnt_a, m_cnt[0]);
        check("cnt_b", cnt_b, m_cnt[1]);
        check("cnt_c", cnt_c, m_cnt[2]);
`endif
        @(posedge clk);
        if (nReset) model_step();
        last_ack = e_ack;
        #1;
    endtask

    task automatic reset_dut();
        nReset = 1'b0;
        #1;
        check("rst_cs", bus.cs, 1'b0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_sel", bus.sel, 2'd0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_ack", bus.ack, 3'b000);
`ifdef MUX_ARB_STATS_EN
        check("rst_cnt", {cnt_a, cnt_b, cnt_c}, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        nReset = 1'b1;
    endtask

    // Requesters keep req and data steady until acknowledged, occasionally withdrawing.
    task automatic drive_random();
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                if (last_ack[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else src[i] = 8'($urandom);
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req[i] = 1'b1;
                src[i] = 8'($urandom);
            end
        end
        out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_STATS_EN
        stats_clr = ($urandom_range(0, 39) == 0);
`endif
    endtask

    initial begin
        src[0] = 8'h00;
        src[1] = 8'h00;
        src[2] = 8'h00;
        model_reset();
        #2;

        // Reset while everyone requests, then alpha wins the first grant.
        req       = 3'b111;
        out_ready = 1'b0;
        reset_dut();
        tick();
        check("t1_sel", bus.sel, 2'd0);
        check("t1_cs", bus.cs, 1'b1);
        req = 3'b000;
        tick();

        // Single beta request with the sink ready.
        req       = 3'b010;
        src[1]    = 8'hA5;
        out_ready = 1'b1;
        tick();
        check("t2_sel", bus.sel, 2'd1);
        check("t2_data", bus.out_data, 8'hA5);
        check("t2_ack", bus.ack, 3'b010);
        req = 3'b000;
        tick();
        check("t2_idle", bus.cs, 1'b0);

        // All requesting: one word per cycle in alpha, beta, gamma order.
        reset_dut();
        src[0]    = 8'h11;
        src[1]    = 8'h22;
        src[2]    = 8'h33;
        req       = 3'b111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_data", bus.out_data, (k % 3 + 1) * 'h11);
            check("t3_ack", bus.ack, 3'b001 << (k % 3));
        end

        // Gamma held under backpressure for five cycles, then accepted once.
        req = 3'b101;
        tick();
        check("t4_sel", bus.sel, 2'd2);
        out_ready = 1'b0;
        req       = 3'b100;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_sel", bus.sel, 2'd2);
            check("t4_hold_data", bus.out_data, 8'h33);
            check("t4_hold_ack", bus.ack, 3'b000);
        end
        out_ready = 1'b1;
        req       = 3'b000;
        #1;
        check("t4_ack", bus.ack, 3'b100);
        tick();
        check("t4_idle", bus.cs, 1'b0);

        // Beta withdraws before acceptance; the pointer still sits after gamma.
        out_ready = 1'b0;
        req       = 3'b010;
        tick();
        check("t5_sel", bus.sel, 2'd1);
        req = 3'b000;
        tick();
        check("t5_cs", bus.cs, 1'b0);
        check("t5_ack", bus.ack, 3'b000);
        req = 3'b111;
        tick();
        check("t5_next", bus.sel, 2'd0);

`ifdef MUX_ARB_STATS_EN
        req = 3'b000;
        reset_dut();
        req       = 3'b001;
        out_ready = 1'b1;
        repeat (6) tick();
        check("t6_cnt3", cnt_a, 2'd3);
        repeat (2) tick();
        check("t6_sat", cnt_a, 2'd3);
        tick();
        stats_clr = 1'b1;
        tick();
        check("t6_clr", cnt_a, 2'd0);
        stats_clr = 1'b0;
`endif

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_dut();
            end
            drive_random();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
